// File: rtl/pipe_hazard_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline with deferred flushes and a hang watchdog.
// Optional performance counters are compiled in with `define PIPE_HAZARD_PERF_EN.
module pipe_hazard_sched #(
  parameter int PC_WIDTH      = 32,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stallreq_from_if_i,
  input  logic                stallreq_from_id_i,
  input  logic                stallreq_from_ex_i,
  input  logic                stallreq_from_mem_i,
  input  logic                flush_req_i,
  input  logic [PC_WIDTH-1:0] flush_pc_i,
  output logic [5:0]          stall_o,
  output logic [5:0]          flush_o,
  output logic                new_pc_valid_o,
  output logic [PC_WIDTH-1:0] new_pc_o,
  output logic                flush_pending_o,
  output logic                hang_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cnt_o,
  output logic [CNT_WIDTH-1:0] perf_flush_cnt_o
`endif
);

  typedef enum logic {RUN, FLUSH_WAIT} state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(STALL_TIMEOUT - 1);

  state_t              state;
  logic [PC_WIDTH-1:0] pend_pc;
  logic [15:0]         stall_cnt;
  logic                hang;
  logic [5:0]          merged_stall;
  logic                deep_stall;
  logic                issue_flush;
  logic [5:0]          stall;

  always_comb begin
    merged_stall = 6'b000000;
    if (stallreq_from_mem_i)     merged_stall = 6'b011111;
    else if (stallreq_from_ex_i) merged_stall = 6'b001111;
    else if (stallreq_from_id_i) merged_stall = 6'b000111;
    else if (stallreq_from_if_i) merged_stall = 6'b000011;
  end

  // A flush can only go out when EX and MEM are moving; otherwise it waits in FLUSH_WAIT.
  assign deep_stall  = stallreq_from_mem_i | stallreq_from_ex_i;
  assign issue_flush = !rst_i && !deep_stall &&
                       ((state == RUN && flush_req_i) || state == FLUSH_WAIT);

  always_comb begin
    stall          = 6'b000000;
    flush_o        = 6'b000000;
    new_pc_valid_o = 1'b0;
    new_pc_o       = '0;
    if (issue_flush) begin
      flush_o        = 6'b000110;
      new_pc_valid_o = 1'b1;
      new_pc_o       = (state == FLUSH_WAIT) ? pend_pc : flush_pc_i;
    end else if (!rst_i) begin
      stall = merged_stall;
    end
  end

  assign stall_o         = stall;
  assign flush_pending_o = (state == FLUSH_WAIT) && !rst_i;
  assign hang_o          = hang && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      pend_pc   <= '0;
      stall_cnt <= '0;
      hang      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (flush_req_i && deep_stall) begin
            state   <= FLUSH_WAIT;
            pend_pc <= flush_pc_i;
          end
        end
        FLUSH_WAIT: begin
          if (!deep_stall) state <= RUN;
        end
        default: state <= RUN;
      endcase
      // Saturating run-length of consecutive stalled cycles; hang latches once it hits the timeout.
      if (stall == 6'b000000) stall_cnt <= '0;
      else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (stall != 6'b000000 && stall_cnt >= TIMEOUT_M1) hang <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] perf_stall_cnt;
  logic [CNT_WIDTH-1:0] perf_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall != 6'b000000 && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (issue_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt_o = rst_i ? '0 : perf_stall_cnt;
  assign perf_flush_cnt_o = rst_i ? '0 : perf_flush_cnt;
`endif

endmodule
